opb_register_simulink2ppc_snap: RTL and testbench

//  Simulink->PPC status register: fabric logic presents a 32-bit word with a valid strobe; the

---
 rtl/opb_reg_pkg.sv | 36 +++
 rtl/opb_slave_ack_fsm.sv | 73 +++++++
 rtl/opb_register_simulink2ppc_snap.sv | 146 ++++++++++++++
 tb/tb_opb_register_simulink2ppc_snap.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_pkg.sv
// Shared types and constants for the OPB register blocks.
// Holds the OPB FSM state enum, register offsets, STATUS bit positions.
package opb_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } opb_state_e;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int STAT_NEW     = 31;
    localparam int STAT_OVR     = 30;
    localparam int STAT_ARM     = 29;
    localparam int STAT_CLR_CNT = 0;

    localparam int CNT_W = 16;

    function automatic logic [31:0] pack_status(
        input logic             nw,
        input logic             ovr,
        input logic             arm,
        input logic [CNT_W-1:0] cnt
    );
        logic [31:0] s;
        s              = '0;
        s[STAT_NEW]    = nw;
        s[STAT_OVR]    = ovr;
        s[STAT_ARM]    = arm;
        s[CNT_W-1:0]   = cnt;
        return s;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and IDLE/ACK/GAP acknowledge FSM.
// Ports: clk, rst_n, abus/dbus/rnw/select in; ack_cycle, rnw_q, offs_q, wdata_q out.
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01060200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010602FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic [0:C_OPB_DWIDTH-1] dbus,
    input  logic                    rnw,
    input  logic                    select,
    output logic                    ack_cycle,
    output logic                    rnw_q,
    output logic [1:0]              offs_q,
    output logic [C_OPB_DWIDTH-1:0] wdata_q
);

    opb_state_e state_q;
    opb_state_e state_d;
    logic       hit;

    assign hit = select
              && (abus >= C_BASEADDR)
              && (abus <= C_HIGHADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are latched only when a new transfer is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnw_q   <= 1'b0;
            offs_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == ST_IDLE && hit) begin
            rnw_q   <= rnw;
            offs_q  <= abus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];
            wdata_q <= dbus;
        end
    end

    // GAP keeps a select that is still high from being acked twice.
    always_comb begin
        state_d   = state_q;
        ack_cycle = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) state_d = ST_ACK;
            end
            ST_ACK: begin
                ack_cycle = 1'b1;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Simulink->PPC snapshot register: captures a fabric word, reads it back over OPB.
// Ports: OPB slave (OPB_*/Sl_*), user_data_in/valid in, user_armed out.
// Optional one-shot arming: define SIMULINK2PPC_ARM_EN.
module opb_register_simulink2ppc_snap
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01060200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010602FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid,
    output logic                    user_armed
);

    localparam int unused_family_bits = $bits(C_FAMILY);

    logic                    ack_cycle;
    logic                    rnw_q;
    logic [1:0]              offs_q;
    logic [C_OPB_DWIDTH-1:0] wdata_q;

    logic [31:0]      data_q;
    logic             new_q;
    logic             ovr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_base;
    logic             arm_bit;
    logic             capture;
    logic             data_rd;
    logic             stat_wr;
    logic [31:0]      rd_word;
    logic             unused_ok;

    assign unused_ok = ^{OPB_BE, OPB_seqAddr, wdata_q};

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    opb_slave_ack_fsm #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_OPB_DWIDTH (C_OPB_DWIDTH)
    ) u_fsm (
        .clk       (OPB_Clk),
        .rst_n     (OPB_Rst_n),
        .abus      (OPB_ABus),
        .dbus      (OPB_DBus),
        .rnw       (OPB_RNW),
        .select    (OPB_select),
        .ack_cycle (ack_cycle),
        .rnw_q     (rnw_q),
        .offs_q    (offs_q),
        .wdata_q   (wdata_q)
    );

    assign capture = user_data_valid & user_armed;
    assign data_rd = ack_cycle & rnw_q & (offs_q == REG_DATA);
    assign stat_wr = ack_cycle & ~rnw_q & (offs_q == REG_STATUS);

`ifdef SIMULINK2PPC_ARM_EN
    logic arm_q;

    // The capture consumes the arm; a same-cycle re-arm loses to it.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            arm_q <= 1'b0;
        end else if (capture) begin
            arm_q <= 1'b0;
        end else if (stat_wr && wdata_q[STAT_ARM]) begin
            arm_q <= 1'b1;
        end
    end

    assign user_armed = arm_q;
    assign arm_bit    = arm_q;
`else
    assign user_armed = 1'b1;
    assign arm_bit    = 1'b0;
`endif

    // Clear is applied first so a coincident capture still counts to 1.
    assign cnt_base = (stat_wr && wdata_q[STAT_CLR_CNT]) ? '0 : cnt_q;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q <= '0;
            new_q  <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (capture) begin
                data_q <= user_data_in;
                new_q  <= 1'b1;
            end else if (data_rd) begin
                new_q  <= 1'b0;
            end
            if (capture && new_q) begin
                ovr_q <= 1'b1;
            end else if (stat_wr && wdata_q[STAT_OVR]) begin
                ovr_q <= 1'b0;
            end
            cnt_q <= cnt_base + {{(CNT_W-1){1'b0}}, capture};
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            (offs_q == REG_DATA):   rd_word = data_q;
            (offs_q == REG_STATUS): rd_word = pack_status(new_q, ovr_q,
                                                          arm_bit, cnt_q);
            default:                rd_word = '0;
        endcase
    end

    // Sl_DBus is sampled from pre-update state, so a read sees data_q
    // as it was before any capture landing in the same ACK cycle.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
        end else begin
            Sl_xferAck <= ack_cycle;
            Sl_DBus    <= (ack_cycle && rnw_q) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Self-checking bench for opb_register_simulink2ppc_snap.
// Directed scenarios plus random traffic against a behavioural register model.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h01060200;

`ifdef SIMULINK2PPC_ARM_EN
    localparam bit ARM = 1'b1;
`else
    localparam bit ARM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:31] OPB_ABus = '0;
    logic [0:3]  OPB_BE = 4'hF;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_RNW = 1'b0;
    logic        OPB_select = 1'b0;
    logic        OPB_seqAddr = 1'b0;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in = '0;
    logic        user_data_valid = 1'b0;
    logic        user_armed;

    int total = 0;
    int bad = 0;

    logic [31:0] m_data;
    logic        m_new;
    logic        m_ovr;
    logic [15:0] m_cnt;
    logic        m_arm;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .OPB_ABus        (OPB_ABus),
        .OPB_BE          (OPB_BE),
        .OPB_DBus        (OPB_DBus),
        .OPB_RNW         (OPB_RNW),
        .OPB_select      (OPB_select),
        .OPB_seqAddr     (OPB_seqAddr),
        .Sl_DBus         (Sl_DBus),
        .Sl_xferAck      (Sl_xferAck),
        .Sl_errAck       (Sl_errAck),
        .Sl_retry        (Sl_retry),
        .Sl_toutSup      (Sl_toutSup),
        .user_data_in    (user_data_in),
        .user_data_valid (user_data_valid),
        .user_armed      (user_armed)
    );

    task automatic m_reset();
        m_data = '0;
        m_new  = 1'b0;
        m_ovr  = 1'b0;
        m_cnt  = '0;
        m_arm  = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        return {m_new, m_ovr, (ARM ? m_arm : 1'b0), 13'b0, m_cnt};
    endfunction

    task automatic m_capture(input logic [31:0] d);
        if (!ARM || m_arm) begin
            if (m_new) m_ovr = 1'b1;
            m_new  = 1'b1;
            m_data = d;
            m_cnt  = m_cnt + 16'd1;
            if (ARM) m_arm = 1'b0;
        end
    endtask

    task automatic m_read(input logic [1:0] offs, input bit inj,
                          input logic [31:0] d, output logic [31:0] rd);
        rd = 32'h0;
        if (offs == 2'd0) begin
            rd = m_data;
            if (inj && (!ARM || m_arm)) m_capture(d);
            else m_new = 1'b0;
        end else if (offs == 2'd1) begin
            rd = m_status();
        end
    endtask

    task automatic m_write(input logic [1:0] offs, input logic [31:0] w);
        if (offs == 2'd1) begin
            if (w[30]) m_ovr = 1'b0;
            if (w[0]) m_cnt = '0;
            if (ARM && w[29]) m_arm = 1'b1;
        end
    endtask

    task automatic xfer(input logic [31:0] addr, input bit rnw,
                        input logic [31:0] wd, input bit inj,
                        input logic [31:0] inj_d,
                        output logic [31:0] rd, output bit got);
        got = 1'b0;
        rd  = '0;
        OPB_ABus   = addr;
        OPB_RNW    = rnw;
        OPB_DBus   = wd;
        OPB_select = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (Sl_xferAck) begin
                got = 1'b1;
                rd  = Sl_DBus;
            end
            @(posedge clk);
            #1;
            if (c == 0 && inj) begin
                user_data_in    = inj_d;
                user_data_valid = 1'b1;
            end else begin
                user_data_valid = 1'b0;
            end
        end
        OPB_select      = 1'b0;
        user_data_valid = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] d);
        user_data_in    = d;
        user_data_valid = 1'b1;
        m_capture(d);
        @(posedge clk);
        #1;
        user_data_valid = 1'b0;
    endtask

    task automatic rearm();
        logic [31:0] rd;
        bit          got;
        if (ARM) begin
            xfer(BASE + 4, 1'b0, 32'h2000_0000, 1'b0, '0, rd, got);
            m_write(2'd1, 32'h2000_0000);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp;
        bit          got;
        int          acks;
        m_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0 || Sl_errAck !== 1'b0
            || Sl_retry !== 1'b0 || Sl_toutSup !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs ack=%b dbus=%h err=%b retry=%b tout=%b",
                     Sl_xferAck, Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup);
        end
        total++;
        if (user_armed !== !ARM) begin
            bad++;
            $display("FAIL reset_armed got=%b exp=%b", user_armed, !ARM);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL reset_status got=%h exp=%h ack=%b", rd, exp, got);
        end
        xfer(BASE, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd0, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL reset_data got=%h exp=%h ack=%b", rd, exp, got);
        end
        OPB_ABus   = BASE + 4;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        OPB_select = 1'b0;
        acks       = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (Sl_xferAck) acks++;
            @(posedge clk);
            #1;
            if (i == 1) rst_n = 1'b1;
        end
        m_reset();
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL reset_midxfer acks=%0d exp=0", acks);
        end
    endtask

    task automatic test_capture();
        logic [31:0] rd;
        logic [31:0] exp;
        bit          got;
        rearm();
        pulse(32'hDEAD_BEEF);
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL cap_status1 got=%h exp=%h", rd, exp);
        end
        xfer(BASE, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd0, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL cap_data got=%h exp=%h", rd, exp);
        end
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL cap_status2 got=%h exp=%h", rd, exp);
        end
        total++;
        if (user_armed !== (!ARM || m_arm)) begin
            bad++;
            $display("FAIL cap_armed got=%b exp=%b", user_armed, !ARM || m_arm);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        logic [31:0] exp;
        bit          got;
        xfer(BASE + 4, 1'b0, 32'h4000_0001, 1'b0, '0, rd, got);
        m_write(2'd1, 32'h4000_0001);
        rearm();
        pulse(32'h1);
        rearm();
        pulse(32'h2);
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL ovr_status got=%h exp=%h", rd, exp);
        end
        xfer(BASE + 4, 1'b0, 32'h4000_0001, 1'b0, '0, rd, got);
        m_write(2'd1, 32'h4000_0001);
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL ovr_clear got=%h exp=%h", rd, exp);
        end
    endtask

    task automatic test_coincident();
        logic [31:0] rd;
        logic [31:0] exp;
        bit          got;
        rearm();
        pulse(32'h44);
        xfer(BASE, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd0, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL coin_pre got=%h exp=%h", rd, exp);
        end
        rearm();
        xfer(BASE, 1'b1, '0, 1'b1, 32'h55, rd, got);
        m_read(2'd0, 1'b1, 32'h55, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL coin_read got=%h exp=%h", rd, exp);
        end
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL coin_status got=%h exp=%h", rd, exp);
        end
        xfer(BASE, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd0, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL coin_data got=%h exp=%h", rd, exp);
        end
    endtask

    task automatic test_hold_select();
        logic [31:0] exp_stat;
        logic [31:0] exp_bus;
        logic [31:0] outside [2];
        logic        exp_ack;
        int          acks;
        exp_stat   = m_status();
        OPB_ABus   = BASE + 4;
        OPB_RNW    = 1'b1;
        OPB_select = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ack = (i == 2 || i == 5);
            exp_bus = exp_ack ? exp_stat : 32'h0;
            total++;
            if (Sl_xferAck !== exp_ack || Sl_DBus !== exp_bus) begin
                bad++;
                $display("FAIL hold_cyc%0d ack=%b dbus=%h exp_ack=%b exp_dbus=%h",
                         i, Sl_xferAck, Sl_DBus, exp_ack, exp_bus);
            end
            @(posedge clk);
            #1;
        end
        OPB_select = 1'b0;
        outside[0] = 32'h0106_0300;
        outside[1] = 32'h0106_01FC;
        for (int k = 0; k < 2; k++) begin
            OPB_ABus   = outside[k];
            OPB_select = 1'b1;
            acks       = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (Sl_xferAck || Sl_DBus != 32'h0) acks++;
                @(posedge clk);
                #1;
            end
            OPB_select = 1'b0;
            total++;
            if (acks != 0) begin
                bad++;
                $display("FAIL miss_addr%0d acks=%0d exp=0", k, acks);
            end
        end
    endtask

`ifdef SIMULINK2PPC_ARM_EN
    task automatic test_arm();
        logic [31:0] rd;
        logic [31:0] exp;
        bit          got;
        xfer(BASE + 4, 1'b0, 32'h4000_0001, 1'b0, '0, rd, got);
        m_write(2'd1, 32'h4000_0001);
        pulse(32'h1234_5678);
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL arm_unarmed got=%h exp=%h", rd, exp);
        end
        xfer(BASE + 4, 1'b0, 32'h2000_0000, 1'b0, '0, rd, got);
        m_write(2'd1, 32'h2000_0000);
        @(negedge clk);
        total++;
        if (user_armed !== 1'b1) begin
            bad++;
            $display("FAIL arm_set got=%b exp=1", user_armed);
        end
        @(posedge clk);
        #1;
        pulse(32'hA);
        pulse(32'hB);
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL arm_oneshot got=%h exp=%h", rd, exp);
        end
        total++;
        if (user_armed !== 1'b0) begin
            bad++;
            $display("FAIL arm_cleared got=%b exp=0", user_armed);
        end
    endtask
`else
    task automatic test_cnt_wrap();
        logic [31:0] rd;
        logic [31:0] exp;
        bit          got;
        xfer(BASE + 4, 1'b0, 32'h0000_0001, 1'b0, '0, rd, got);
        m_write(2'd1, 32'h0000_0001);
        user_data_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            user_data_in = $urandom;
            m_capture(user_data_in);
            @(posedge clk);
            #1;
        end
        user_data_valid = 1'b0;
        xfer(BASE + 4, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd1, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL wrap_status got=%h exp=%h", rd, exp);
        end
        xfer(BASE, 1'b1, '0, 1'b0, '0, rd, got);
        m_read(2'd0, 1'b0, '0, exp);
        total++;
        if (!got || rd !== exp) begin
            bad++;
            $display("FAIL wrap_data got=%h exp=%h", rd, exp);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] a;
        logic [31:0] w;
        logic [1:0]  offs;
        bit          got;
        int          op;
        for (int n = 0; n < 300; n++) begin
            op   = $urandom_range(0, 5);
            a    = BASE + ($urandom_range(0, 63) << 2);
            offs = a[3:2];
            w    = $urandom;
            case (op)
                0, 5: pulse($urandom);
                1, 2: begin
                    m_read(offs, 1'b0, '0, exp);
                    xfer(a, 1'b1, '0, 1'b0, '0, rd, got);
                    total++;
                    if (!got || rd !== exp) begin
                        bad++;
                        $display("FAIL rnd_read n=%0d addr=%h got=%h exp=%h ack=%b",
                                 n, a, rd, exp, got);
                    end
                end
                3: begin
                    a = BASE + 4 + ($urandom_range(0, 15) << 4);
                    xfer(a, 1'b0, w, 1'b0, '0, rd, got);
                    m_write(2'd1, w);
                    total++;
                    if (!got) begin
                        bad++;
                        $display("FAIL rnd_stwr n=%0d ack=%b exp=1", n, got);
                    end
                end
                default: begin
                    xfer(a, 1'b0, w, 1'b0, '0, rd, got);
                    m_write(offs, w);
                end
            endcase
            total++;
            if (user_armed !== (!ARM || m_arm)) begin
                bad++;
                $display("FAIL rnd_armed n=%0d got=%b exp=%b",
                         n, user_armed, !ARM || m_arm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_overrun();
        test_coincident();
        test_hold_select();
`ifdef SIMULINK2PPC_ARM_EN
        test_arm();
`else
        test_cnt_wrap();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
